// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register of the 5-stage ARM core.
// Supports stall (hold), flush (bubble) and a per-slot valid bit that gates the control word.
module id_exe_stage_reg #(
  parameter int DATA_W    = 32,
  parameter int CMD_W     = 4,
  parameter int REG_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [CMD_W-1:0]     exe_cmd_in,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic                 wb_enable_in,
  input  logic                 branch_taken_in,
  input  logic                 status_write_enable_in,
  input  logic                 imm_in,
  input  logic [11:0]          shift_operand_in,
  input  logic [23:0]          signed_imm24_in,
  input  logic [REG_IDX_W-1:0] dest_in,
  input  logic [REG_IDX_W-1:0] src1_idx_in,
  input  logic [REG_IDX_W-1:0] src2_idx_in,
  input  logic [DATA_W-1:0]    val_rn_in,
  input  logic [DATA_W-1:0]    val_rm_in,
  input  logic [DATA_W-1:0]    pc_in,
  input  logic [3:0]           status_in,
  output logic                 valid_out,
  output logic [CMD_W-1:0]     exe_cmd_out,
  output logic                 mem_read_out,
  output logic                 mem_write_out,
  output logic                 wb_enable_out,
  output logic                 branch_taken_out,
  output logic                 status_write_enable_out,
  output logic                 imm_out,
  output logic [11:0]          shift_operand_out,
  output logic [23:0]          signed_imm24_out,
  output logic [REG_IDX_W-1:0] dest_out,
  output logic [REG_IDX_W-1:0] src1_idx_out,
  output logic [REG_IDX_W-1:0] src2_idx_out,
  output logic [DATA_W-1:0]    val_rn_out,
  output logic [DATA_W-1:0]    val_rm_out,
  output logic [DATA_W-1:0]    pc_out,
  output logic [3:0]           status_out
);

  localparam int CTRL_W = CMD_W + 5;
  localparam int DW     = 1 + 12 + 24 + 3 * REG_IDX_W + 3 * DATA_W + 4;

  logic [CTRL_W-1:0] ctrl_in_s;
  logic [DW-1:0]     data_in_s;

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
  logic [DW-1:0]     data_d,  data_q;

  assign ctrl_in_s = {exe_cmd_in, mem_read_in, mem_write_in, wb_enable_in,
                      branch_taken_in, status_write_enable_in};

  assign data_in_s = {imm_in, shift_operand_in, signed_imm24_in, dest_in,
                      src1_idx_in, src2_idx_in, val_rn_in, val_rm_in, pc_in,
                      status_in};

  // Next-slot selection: flush beats freeze beats load; control gated by valid_in
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = {CTRL_W{1'b0}};
      data_d  = {DW{1'b0}};
    end else if (freeze) begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
    end else begin
      valid_d = valid_in;
      ctrl_d  = valid_in ? ctrl_in_s : {CTRL_W{1'b0}};
      data_d  = data_in_s;
    end
  end

  // Slot register with synchronous reset that overrides freeze and flush
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= {CTRL_W{1'b0}};
      data_q  <= {DW{1'b0}};
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;

  assign {exe_cmd_out, mem_read_out, mem_write_out, wb_enable_out,
          branch_taken_out, status_write_enable_out} = ctrl_q;

  assign {imm_out, shift_operand_out, signed_imm24_out, dest_out,
          src1_idx_out, src2_idx_out, val_rn_out, val_rm_out, pc_out,
          status_out} = data_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed test plan steps followed by
// randomized traffic checked against a slot-level reference model.
module tb_id_exe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        bt;
    logic        swe;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] pc;
    logic [3:0]  st;
  } slot_t;

  logic  clk = 1'b0;
  logic  rst, freeze, flush;
  slot_t din, dout, exp_s;
  int    tests = 0;
  int    fails = 0;

  logic        valid_out, mem_read_out, mem_write_out, wb_enable_out;
  logic        branch_taken_out, status_write_enable_out, imm_out;
  logic [3:0]  exe_cmd_out, dest_out, src1_idx_out, src2_idx_out, status_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [31:0] val_rn_out, val_rm_out, pc_out;

  always #5 clk = ~clk;

  id_exe_stage_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .valid_in(din.valid), .exe_cmd_in(din.cmd),
    .mem_read_in(din.mr), .mem_write_in(din.mw), .wb_enable_in(din.wb),
    .branch_taken_in(din.bt), .status_write_enable_in(din.swe),
    .imm_in(din.imm), .shift_operand_in(din.shop), .signed_imm24_in(din.simm),
    .dest_in(din.dest), .src1_idx_in(din.s1), .src2_idx_in(din.s2),
    .val_rn_in(din.rn), .val_rm_in(din.rm), .pc_in(din.pc), .status_in(din.st),
    .valid_out(valid_out), .exe_cmd_out(exe_cmd_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .wb_enable_out(wb_enable_out), .branch_taken_out(branch_taken_out),
    .status_write_enable_out(status_write_enable_out),
    .imm_out(imm_out), .shift_operand_out(shift_operand_out),
    .signed_imm24_out(signed_imm24_out), .dest_out(dest_out),
    .src1_idx_out(src1_idx_out), .src2_idx_out(src2_idx_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .pc_out(pc_out),
    .status_out(status_out)
  );

  assign dout = {valid_out, exe_cmd_out, mem_read_out, mem_write_out,
                 wb_enable_out, branch_taken_out, status_write_enable_out,
                 imm_out, shift_operand_out, signed_imm24_out, dest_out,
                 src1_idx_out, src2_idx_out, val_rn_out, val_rm_out, pc_out,
                 status_out};

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic slot_t rand_slot();
    slot_t s;
    s = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return s;
  endfunction

  function automatic slot_t blank();
    slot_t s;
    s = '0;
    return s;
  endfunction

  // One clock: drive inputs, update the reference model at the edge, check half a cycle later
  task automatic step(input logic r, input logic fz, input logic fl, input slot_t d);
    logic [8:0] ctl;
    rst = r; freeze = fz; flush = fl; din = d;
    @(posedge clk);
    if (r || fl) begin
      exp_s = '0;
    end else if (!fz) begin
      exp_s = d;
      if (!d.valid) begin
        exp_s.cmd = 4'd0; exp_s.mr = 1'b0; exp_s.mw = 1'b0;
        exp_s.wb = 1'b0; exp_s.bt = 1'b0; exp_s.swe = 1'b0;
      end
    end
    @(negedge clk);
    chk("slot", 192'(dout), 192'(exp_s));
    ctl = {dout.cmd, dout.mr, dout.mw, dout.wb, dout.bt, dout.swe};
    chk("ctrl_needs_valid", 192'(dout.valid ? 9'd0 : ctl), 192'(0));
  endtask

  initial begin
    slot_t s;
    exp_s = '0;

    // Reset with every input driven nonzero
    s = '1;
    step(1'b1, 1'b1, 1'b1, s);
    step(1'b1, 1'b0, 1'b0, s);
    chk("reset_all_zero", 192'(dout), 192'(0));

    // Load ADD
    s = blank(); s.valid = 1'b1; s.cmd = 4'b0010; s.wb = 1'b1; s.dest = 4'd3;
    s.rn = 32'h10; s.pc = 32'h8; s.st = 4'b0010;
    step(1'b0, 1'b0, 1'b0, s);
    chk("add_valid", 192'(valid_out), 192'(1));
    chk("add_cmd", 192'(exe_cmd_out), 192'(4'b0010));
    chk("add_rn", 192'(val_rn_out), 192'(32'h10));
    chk("add_pc", 192'(pc_out), 192'(32'h8));

    // Load SUB then freeze for three cycles with CMP on the inputs
    s = blank(); s.valid = 1'b1; s.cmd = 4'b0100; s.wb = 1'b1; s.dest = 4'd5; s.st = 4'b0010;
    step(1'b0, 1'b0, 1'b0, s);
    s = blank(); s.valid = 1'b1; s.cmd = 4'b0101; s.swe = 1'b1; s.rn = 32'h7; s.st = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, s);
      chk("freeze_hold_sub", 192'(exe_cmd_out), 192'(4'b0100));
      chk("freeze_hold_status", 192'(status_out), 192'(4'b0010));
    end
    step(1'b0, 1'b0, 1'b0, s);
    chk("cmp_swe", 192'(status_write_enable_out), 192'(1));
    chk("cmp_wb", 192'(wb_enable_out), 192'(0));

    // LDR in register, then flush with STR on the inputs
    s = blank(); s.valid = 1'b1; s.cmd = 4'b0010; s.mr = 1'b1; s.wb = 1'b1; s.dest = 4'd1;
    step(1'b0, 1'b0, 1'b0, s);
    chk("ldr_visible", 192'(mem_read_out), 192'(1));
    s = blank(); s.valid = 1'b1; s.cmd = 4'b0010; s.mw = 1'b1; s.rm = 32'h55;
    step(1'b0, 1'b0, 1'b1, s);
    chk("flush_mw", 192'(mem_write_out), 192'(0));
    chk("flush_valid", 192'(valid_out), 192'(0));
    chk("flush_cmd", 192'(exe_cmd_out), 192'(0));

    // Flush and freeze together with a valid MOV loaded
    s = blank(); s.valid = 1'b1; s.cmd = 4'b0001; s.wb = 1'b1; s.rm = 32'h1234;
    step(1'b0, 1'b0, 1'b0, s);
    step(1'b0, 1'b1, 1'b1, s);
    chk("flush_freeze_valid", 192'(valid_out), 192'(0));
    chk("flush_freeze_wb", 192'(wb_enable_out), 192'(0));

    // Invalid slot: controls gated, data still loads
    s = blank(); s.valid = 1'b0; s.wb = 1'b1; s.mw = 1'b1; s.rm = 32'hDEAD;
    step(1'b0, 1'b0, 1'b0, s);
    chk("inv_wb", 192'(wb_enable_out), 192'(0));
    chk("inv_mw", 192'(mem_write_out), 192'(0));
    chk("inv_rm", 192'(val_rm_out), 192'(32'hDEAD));
    chk("inv_valid", 192'(valid_out), 192'(0));

    // Reset while frozen discards a valid instruction
    s = rand_slot(); s.valid = 1'b1;
    step(1'b0, 1'b0, 1'b0, s);
    step(1'b1, 1'b1, 1'b0, rand_slot());
    chk("reset_frozen", 192'(dout), 192'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = rand_slot();
      s.valid = ($urandom_range(3) != 0);
      step(($urandom_range(31) == 0), ($urandom_range(3) == 0),
           ($urandom_range(7) == 0), s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
